// File: rtl/axi_aw_router.sv
// AW crossbar stage: round-robin NUM_M masters into one registered slot, decoded to NUM_S slaves + default; route FIFO feeds the W mux.
// Accept in cycle n -> AWVALID_S in n+1; masters see AWREADY_M=0 while the slot is stalled or slot+FIFO occupancy reaches RQ_DEPTH.
module axi_aw_router #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 4,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [NUM_S*ADDR_BITS-1:0] SLV_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_BITS-1:0] SLV_MASK = {4{32'hFFFF_0000}},
  parameter int RQ_DEPTH  = 4,
  localparam int MIDX_BITS = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SIDX_BITS = $clog2(NUM_S + 1),
  localparam int IDS_BITS  = ID_BITS + MIDX_BITS
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_M*ID_BITS-1:0]          AWID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]        AWADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]         AWLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0]        AWSIZE_M,
  input  logic [NUM_M*2-1:0]                AWBURST_M,
  input  logic [NUM_M-1:0]                  AWVALID_M,
  output logic [NUM_M-1:0]                  AWREADY_M,
  output logic [(NUM_S+1)*IDS_BITS-1:0]     AWID_S,
  output logic [(NUM_S+1)*ADDR_BITS-1:0]    AWADDR_S,
  output logic [(NUM_S+1)*LEN_BITS-1:0]     AWLEN_S,
  output logic [(NUM_S+1)*SIZE_BITS-1:0]    AWSIZE_S,
  output logic [(NUM_S+1)*2-1:0]            AWBURST_S,
  output logic [NUM_S:0]                    AWVALID_S,
  input  logic [NUM_S:0]                    AWREADY_S,
  output logic                              W_ROUTE_VALID,
  output logic [MIDX_BITS-1:0]              W_ROUTE_MST,
  output logic [SIDX_BITS-1:0]              W_ROUTE_SLV,
  input  logic                              W_ROUTE_POP
);

  localparam int PTR_BITS = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(RQ_DEPTH + 1);

  logic                 hold_v_q, hold_v_d;
  logic [IDS_BITS-1:0]  hold_id_q, hold_id_d;
  logic [ADDR_BITS-1:0] hold_addr_q, hold_addr_d;
  logic [LEN_BITS-1:0]  hold_len_q, hold_len_d;
  logic [SIZE_BITS-1:0] hold_size_q, hold_size_d;
  logic [1:0]           hold_burst_q, hold_burst_d;
  logic [SIDX_BITS-1:0] hold_slv_q, hold_slv_d;
  logic [MIDX_BITS-1:0] hold_mst_q, hold_mst_d;
  logic [MIDX_BITS-1:0] rr_q, rr_d;

  logic [MIDX_BITS-1:0] rq_mst_q [RQ_DEPTH];
  logic [SIDX_BITS-1:0] rq_slv_q [RQ_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [CNT_BITS:0]    occupancy;

  logic                 hold_fire, acc, rq_push, rq_pop, grant_hit;
  logic [MIDX_BITS-1:0] grant;
  logic [ID_BITS-1:0]   g_id;
  logic [ADDR_BITS-1:0] g_addr;
  logic [LEN_BITS-1:0]  g_len;
  logic [SIZE_BITS-1:0] g_size;
  logic [1:0]           g_burst;
  logic [SIDX_BITS-1:0] g_slv;

  // Round-robin: masters above rr_q first, then wrap to the lower ones.
  always_comb begin
    grant     = '0;
    grant_hit = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!grant_hit && AWVALID_M[k] && (k > int'(rr_q))) begin
        grant_hit = 1'b1;
        grant     = MIDX_BITS'(k);
      end
    end
    for (int k = 0; k < NUM_M; k++) begin
      if (!grant_hit && AWVALID_M[k] && (k <= int'(rr_q))) begin
        grant_hit = 1'b1;
        grant     = MIDX_BITS'(k);
      end
    end
  end

  always_comb begin
    g_id    = '0;
    g_addr  = '0;
    g_len   = '0;
    g_size  = '0;
    g_burst = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant == MIDX_BITS'(k)) begin
        g_id    = AWID_M[k*ID_BITS +: ID_BITS];
        g_addr  = AWADDR_M[k*ADDR_BITS +: ADDR_BITS];
        g_len   = AWLEN_M[k*LEN_BITS +: LEN_BITS];
        g_size  = AWSIZE_M[k*SIZE_BITS +: SIZE_BITS];
        g_burst = AWBURST_M[k*2 +: 2];
      end
    end
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    g_slv = SIDX_BITS'(NUM_S);
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((g_addr & SLV_MASK[i*ADDR_BITS +: ADDR_BITS]) == SLV_BASE[i*ADDR_BITS +: ADDR_BITS])
        g_slv = SIDX_BITS'(i);
    end
  end

  // A same-cycle route pop is deliberately not credited to acceptance.
  assign hold_fire = hold_v_q & AWREADY_S[hold_slv_q];
  assign occupancy = {1'b0, count_q} + {{CNT_BITS{1'b0}}, hold_v_q};
  assign acc       = (!hold_v_q || hold_fire) && (occupancy < (CNT_BITS+1)'(RQ_DEPTH)) && (|AWVALID_M);
  assign rq_push   = hold_fire;
  assign rq_pop    = W_ROUTE_POP && (count_q != '0);

  always_comb begin
    hold_v_d     = hold_v_q;
    hold_id_d    = hold_id_q;
    hold_addr_d  = hold_addr_q;
    hold_len_d   = hold_len_q;
    hold_size_d  = hold_size_q;
    hold_burst_d = hold_burst_q;
    hold_slv_d   = hold_slv_q;
    hold_mst_d   = hold_mst_q;
    rr_d         = rr_q;
    if (acc) begin
      hold_v_d     = 1'b1;
      hold_id_d    = {grant, g_id};
      hold_addr_d  = g_addr;
      hold_len_d   = g_len;
      hold_size_d  = g_size;
      hold_burst_d = g_burst;
      hold_slv_d   = g_slv;
      hold_mst_d   = grant;
      rr_d         = grant;
    end else if (hold_fire) begin
      hold_v_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rq_push)
      wr_ptr_d = (wr_ptr_q == PTR_BITS'(RQ_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_BITS'(1);
    if (rq_pop)
      rd_ptr_d = (rd_ptr_q == PTR_BITS'(RQ_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_BITS'(1);
    if (rq_push && !rq_pop)
      count_d = count_q + CNT_BITS'(1);
    else if (!rq_push && rq_pop)
      count_d = count_q - CNT_BITS'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hold_v_q     <= 1'b0;
      hold_id_q    <= '0;
      hold_addr_q  <= '0;
      hold_len_q   <= '0;
      hold_size_q  <= '0;
      hold_burst_q <= '0;
      hold_slv_q   <= '0;
      hold_mst_q   <= '0;
      rr_q         <= MIDX_BITS'(NUM_M - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        rq_mst_q[i] <= '0;
        rq_slv_q[i] <= '0;
      end
    end else begin
      hold_v_q     <= hold_v_d;
      hold_id_q    <= hold_id_d;
      hold_addr_q  <= hold_addr_d;
      hold_len_q   <= hold_len_d;
      hold_size_q  <= hold_size_d;
      hold_burst_q <= hold_burst_d;
      hold_slv_q   <= hold_slv_d;
      hold_mst_q   <= hold_mst_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (rq_push) begin
        rq_mst_q[wr_ptr_q] <= hold_mst_q;
        rq_slv_q[wr_ptr_q] <= hold_slv_q;
      end
    end
  end

  always_comb begin
    AWREADY_M = '0;
    for (int k = 0; k < NUM_M; k++)
      AWREADY_M[k] = acc && (grant == MIDX_BITS'(k));
    AWVALID_S = '0;
    for (int j = 0; j <= NUM_S; j++)
      AWVALID_S[j] = hold_v_q && (hold_slv_q == SIDX_BITS'(j));
  end

  assign AWID_S        = {(NUM_S+1){hold_id_q}};
  assign AWADDR_S      = {(NUM_S+1){hold_addr_q}};
  assign AWLEN_S       = {(NUM_S+1){hold_len_q}};
  assign AWSIZE_S      = {(NUM_S+1){hold_size_q}};
  assign AWBURST_S     = {(NUM_S+1){hold_burst_q}};
  assign W_ROUTE_VALID = (count_q != '0);
  assign W_ROUTE_MST   = rq_mst_q[rd_ptr_q];
  assign W_ROUTE_SLV   = rq_slv_q[rd_ptr_q];

endmodule
